// File: rtl/chip8_gpu_pkg.sv
// Shared opcode constants, issuer state encoding and display-opcode classifier
// for the CHIP-8 GPU command queue.
package chip8_gpu_pkg;

  localparam logic [15:0] OP_CLS     = 16'h00E0;
  localparam logic [3:0]  OP_DRW_NIB = 4'hD;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StAck,
    StBusy
  } issue_state_e;

  function automatic logic is_display_op(input logic [15:0] op);
    return (op == OP_CLS) || (op[15:12] == OP_DRW_NIB);
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Command FIFO with wrap-bit pointers. With GPU_CMD_COALESCE_EN defined it also
// exposes the most recently written (tail) entry.
module gpu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CMD_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [CMD_W-1:0]           wdata,
  input  logic                       pop,
  output logic [CMD_W-1:0]           rdata,
`ifdef GPU_CMD_COALESCE_EN
  output logic [CMD_W-1:0]           tail_data,
`endif
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

`ifdef GPU_CMD_COALESCE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx  = wr_ptr_q[AW-1:0] - AW'(1);
  assign tail_data = mem_q[tail_idx];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Filters and queues CHIP-8 display opcodes and issues them one at a time to the gpu.
// Optional macro GPU_CMD_COALESCE_EN drops a CLS arriving behind a queued CLS.
module gpu_cmd_queue
  import chip8_gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CMD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_W-1:0]       cmd_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [CMD_W-1:0]       gpu_cmd,
  output logic                   gpu_cmd_submitted,
  input  logic                   gpu_ready,
  output logic                   all_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_illegal,
  output logic                   err_overflow
);

  logic             xfer, legal, coalesce, push, pop, full, empty;
  logic [CMD_W-1:0] head;
  issue_state_e     state_q;
  logic             ack_wait_q;

  assign cmd_ready = !full;
  assign xfer      = cmd_valid && cmd_ready;
  assign legal     = is_display_op(cmd_in);

`ifdef GPU_CMD_COALESCE_EN
  logic [CMD_W-1:0] tail;
  assign coalesce = (cmd_in == OP_CLS) && !empty && (tail == OP_CLS);
`else
  assign coalesce = 1'b0;
`endif

  assign push     = xfer && legal && !coalesce;
  assign pop      = (state_q == StIdle) && !empty && gpu_ready;
  assign all_done = empty && (state_q == StIdle) && gpu_ready;

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (cmd_in),
    .pop       (pop),
    .rdata     (head),
`ifdef GPU_CMD_COALESCE_EN
    .tail_data (tail),
`endif
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      ack_wait_q        <= 1'b0;
      gpu_cmd           <= '0;
      gpu_cmd_submitted <= 1'b0;
      err_illegal       <= 1'b0;
      err_overflow      <= 1'b0;
    end else begin
      gpu_cmd_submitted <= 1'b0;
      if (xfer && !legal)          err_illegal  <= 1'b1;
      if (cmd_valid && !cmd_ready) err_overflow <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            gpu_cmd           <= head;
            gpu_cmd_submitted <= 1'b1;
            state_q           <= StIssue;
          end
        end
        StIssue: begin
          ack_wait_q <= 1'b0;
          state_q    <= StAck;
        end
        StAck: begin
          // A gpu that never drops ready has finished the command already.
          if (!gpu_ready)      state_q    <= StBusy;
          else if (ack_wait_q) state_q    <= StIdle;
          else                 ack_wait_q <= 1'b1;
        end
        StBusy: begin
          if (gpu_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed self-checking bench for gpu_cmd_queue with a simple busy-for-N gpu model.
module tb_gpu_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_in = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] gpu_cmd;
  logic        gpu_cmd_submitted;
  logic        gpu_ready = 1'b1;
  logic        all_done;
  logic [2:0]  level;
  logic        err_illegal;
  logic        err_overflow;

  int n_checks = 0;
  int n_errs   = 0;

  int          gpu_n = 5;
  int          busy  = 0;
  logic [15:0] sub_log[$];
  int          dbl_pulses = 0;
  logic        prev_sub = 1'b0;
  int          max_level = 0;
  int          not_ready = 0;

  gpu_cmd_queue #(
    .DEPTH (4),
    .CMD_W (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_in            (cmd_in),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .gpu_cmd           (gpu_cmd),
    .gpu_cmd_submitted (gpu_cmd_submitted),
    .gpu_ready         (gpu_ready),
    .all_done          (all_done),
    .level             (level),
    .err_illegal       (err_illegal),
    .err_overflow      (err_overflow)
  );

  always #5 clk = ~clk;

  // gpu model: leaves ready after seeing a submit pulse, returns N cycles later.
  always @(posedge clk) begin
    #2;
    if (gpu_cmd_submitted) begin
      gpu_ready = 1'b0;
      busy      = gpu_n;
    end else if (busy > 0) begin
      busy = busy - 1;
      if (busy == 0) gpu_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && gpu_cmd_submitted) begin
      sub_log.push_back(gpu_cmd);
      if (prev_sub) dbl_pulses++;
    end
    prev_sub = gpu_cmd_submitted;
    if (int'(level) > max_level) max_level = int'(level);
    if (!cmd_ready) not_ready++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < sub_log.size()) return sub_log[i];
    return 16'hxxxx;
  endfunction

  task automatic push(input logic [15:0] c);
    cmd_valid = 1'b1;
    cmd_in    = c;
    @(negedge clk);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_in    = '0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!all_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, all_done}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset state and single command latency
    gpu_n = 5;
    @(negedge clk);
    do_reset();
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_sub", 32'(gpu_cmd_submitted), 32'd0);
    check("rst_gpu_cmd", 32'(gpu_cmd), 32'd0);
    check("rst_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
    check("rst_all_done", 32'(all_done), 32'd1);
    sub_log.delete();
    push(16'hD125);
    idle();
    check("t1_level", 32'(level), 32'd1);
    check("t1_no_early_sub", 32'(gpu_cmd_submitted), 32'd0);
    @(negedge clk);
    check("t1_sub_at_2", 32'(gpu_cmd_submitted), 32'd1);
    check("t1_gpu_cmd", 32'(gpu_cmd), 32'hD125);
    check("t1_not_done", 32'(all_done), 32'd0);
    @(negedge clk);
    check("t1_pulse_one_cycle", 32'(gpu_cmd_submitted), 32'd0);
    wait_done("t1_done", 50);
    check("t1_count", 32'(sub_log.size()), 32'd1);
    check("t1_cmd_held", 32'(gpu_cmd), 32'hD125);

    // 2: back-to-back pushes, FIFO order
    gpu_n = 10;
    sub_log.delete();
    max_level = 0;
    not_ready = 0;
    push(16'h00E0);
    push(16'hD011);
    push(16'hD122);
    push(16'hD233);
    idle();
    wait_done("t2_done", 300);
    check("t2_count", 32'(sub_log.size()), 32'd4);
    check("t2_ord0", 32'(log_at(0)), 32'h00E0);
    check("t2_ord1", 32'(log_at(1)), 32'hD011);
    check("t2_ord2", 32'(log_at(2)), 32'hD122);
    check("t2_ord3", 32'(log_at(3)), 32'hD233);
    check("t2_peak", 32'(max_level), 32'd3);
    check("t2_ready", 32'(not_ready), 32'd0);

    // 3: overflow with a slow gpu
    gpu_n = 50;
    sub_log.delete();
    push(16'hD001);
    push(16'hD002);
    push(16'hD003);
    push(16'hD004);
    push(16'hD005);
    check("t3_full_level", 32'(level), 32'd4);
    check("t3_full_ready", 32'(cmd_ready), 32'd0);
    check("t3_no_ovf_yet", 32'(err_overflow), 32'd0);
    push(16'hD006);
    idle();
    check("t3_ovf", 32'(err_overflow), 32'd1);
    check("t3_level_kept", 32'(level), 32'd4);
    wait_done("t3_done", 800);
    check("t3_count", 32'(sub_log.size()), 32'd5);
    check("t3_first", 32'(log_at(0)), 32'hD001);
    check("t3_last", 32'(log_at(4)), 32'hD005);

    // 4: illegal opcode filtered
    gpu_n = 5;
    sub_log.delete();
    check("t4_ill_clear", 32'(err_illegal), 32'd0);
    push(16'h8123);
    idle();
    check("t4_ill", 32'(err_illegal), 32'd1);
    check("t4_level", 32'(level), 32'd0);
    repeat (5) @(negedge clk);
    check("t4_no_sub", 32'(sub_log.size()), 32'd0);

    // 5: CLS coalescing (or not)
    do_reset();
    sub_log.delete();
    push(16'h00E0);
    push(16'h00E0);
    push(16'hD011);
    idle();
    wait_done("t5_done", 200);
`ifdef GPU_CMD_COALESCE_EN
    check("t5_count", 32'(sub_log.size()), 32'd2);
    check("t5_ord1", 32'(log_at(1)), 32'hD011);
`else
    check("t5_count", 32'(sub_log.size()), 32'd3);
    check("t5_ord1", 32'(log_at(1)), 32'h00E0);
    check("t5_ord2", 32'(log_at(2)), 32'hD011);
`endif
    check("t5_ord0", 32'(log_at(0)), 32'h00E0);

    // 6: reset while busy with entries queued
    gpu_n = 50;
    push(16'hD001);
    idle();
    begin
      int n = 0;
      while (gpu_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_gpu_busy", 32'(gpu_ready), 32'd0);
    push(16'hD002);
    push(16'h8000);
    push(16'hD003);
    idle();
    check("t6_level", 32'(level), 32'd2);
    check("t6_ill_set", 32'(err_illegal), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_sub", 32'(gpu_cmd_submitted), 32'd0);
    check("t6_rst_errs", {30'd0, err_illegal, err_overflow}, 32'd0);
    rst_n = 1'b1;
    sub_log.delete();
    repeat (80) @(negedge clk);
    check("t6_no_issue", 32'(sub_log.size()), 32'd0);
    check("t6_level_end", 32'(level), 32'd0);
    check("t6_done", 32'(all_done), 32'd1);

    check("no_double_pulse", 32'(dbl_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
